// File: rtl/instruction_fetch.sv
// instruction_fetch: IF stage with IF/ID pipeline register.
// Generates the 12-bit byte PC and drives a synchronous-read instruction memory.
// A one-entry skid buffer keeps an in-flight memory response safe across stalls.
// Flushes on JAL redirects from decode and on branch/JALR redirects from execute.
// Optional feature: define IF_ECALL_HALT_EN to stop fetching when decode reports ECALL.
// Without it, ecall_id is ignored and halted is tied low.
module instruction_fetch #(
    parameter logic [11:0] RESET_PC  = 12'h000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect_id,
    input  logic [11:0] redirect_id_target,
    input  logic        redirect_ex,
    input  logic [11:0] redirect_ex_target,
    input  logic        ecall_id,
    output logic        imem_req,
    output logic [11:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        if_id_valid,
    output logic [11:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        halted
);

    // Next address to issue
    logic [11:0] pc_q, pc_d;
    // Tracks the request issued in the previous cycle (its data is on imem_rdata now)
    logic        resp_valid_q, resp_valid_d;
    logic [11:0] resp_pc_q, resp_pc_d;
    // Skid entry holding a response that arrived while IF/ID was stalled
    logic        skid_valid_q, skid_valid_d;
    logic [11:0] skid_pc_q, skid_pc_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    // IF/ID pipeline register
    logic        ifid_valid_q, ifid_valid_d;
    logic [11:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    // Fetch stopped on ECALL
    logic        halted_q, halted_d;

    logic        flush;
    logic [11:0] flush_target;
    logic        halt_entry;

`ifdef IF_ECALL_HALT_EN
    // Halt when decode holds a real ECALL and nothing of higher priority is acting
    assign halt_entry = ecall_id && ifid_valid_q && !stall && !redirect_ex;
    assign halted     = halted_q;
`else
    logic unused_ecall;
    assign unused_ecall = ecall_id;
    assign halt_entry   = 1'b0;
    assign halted       = 1'b0;
`endif

    // Memory request: nothing issued while stalled, halted or being redirected
    assign imem_req    = !stall && !halted_q && !redirect_ex && !redirect_id;
    assign imem_addr   = pc_q;

    assign if_id_valid = ifid_valid_q;
    assign if_id_pc    = ifid_pc_q;
    assign if_id_instr = ifid_instr_q;

    // Redirect select: execute wins over decode; decode redirects are dropped
    // while stalled or halted (halt exits only through execute or reset)
    always_comb begin
        flush        = redirect_ex || (redirect_id && !stall && !halted_q);
        flush_target = redirect_ex ? redirect_ex_target : redirect_id_target;
    end

    // Next-state logic in priority order: redirect > halted/halt entry > stall > normal
    always_comb begin
        pc_d         = pc_q;
        resp_valid_d = resp_valid_q;
        resp_pc_d    = resp_pc_q;
        skid_valid_d = skid_valid_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        ifid_valid_d = ifid_valid_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        halted_d     = halted_q;

        if (flush) begin
            pc_d         = flush_target;
            resp_valid_d = 1'b0;
            skid_valid_d = 1'b0;
            ifid_valid_d = 1'b0;
            ifid_pc_d    = '0;
            ifid_instr_d = NOP_INSTR;
            halted_d     = 1'b0;
        end else if (halted_q || halt_entry) begin
            // PC frozen; in-flight data dropped; decode sees bubbles
            halted_d     = 1'b1;
            resp_valid_d = 1'b0;
            skid_valid_d = 1'b0;
            ifid_valid_d = 1'b0;
            ifid_pc_d    = '0;
            ifid_instr_d = NOP_INSTR;
        end else if (stall) begin
            // IF/ID and PC hold; park the one response that is still arriving
            resp_valid_d = 1'b0;
            if (resp_valid_q && !skid_valid_q) begin
                skid_valid_d = 1'b1;
                skid_pc_d    = resp_pc_q;
                skid_instr_d = imem_rdata;
            end
        end else begin
            pc_d         = pc_q + 12'd4;
            resp_valid_d = 1'b1;
            resp_pc_d    = pc_q;
            if (skid_valid_q) begin
                skid_valid_d = 1'b0;
                ifid_valid_d = 1'b1;
                ifid_pc_d    = skid_pc_q;
                ifid_instr_d = skid_instr_q;
            end else if (resp_valid_q) begin
                ifid_valid_d = 1'b1;
                ifid_pc_d    = resp_pc_q;
                ifid_instr_d = imem_rdata;
            end else begin
                ifid_valid_d = 1'b0;
                ifid_pc_d    = '0;
                ifid_instr_d = NOP_INSTR;
            end
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= RESET_PC;
            resp_valid_q <= 1'b0;
            resp_pc_q    <= '0;
            skid_valid_q <= 1'b0;
            skid_pc_q    <= '0;
            skid_instr_q <= '0;
            ifid_valid_q <= 1'b0;
            ifid_pc_q    <= '0;
            ifid_instr_q <= NOP_INSTR;
            halted_q     <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            resp_valid_q <= resp_valid_d;
            resp_pc_q    <= resp_pc_d;
            skid_valid_q <= skid_valid_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            halted_q     <= halted_d;
        end
    end

endmodule
